// File: rtl/main_mem_resp.sv
// Fixed-latency main memory model: 256 x 32-bit words, block (4-word) reads and single-word writes.
// One request in flight at a time; ready pulses LATENCY cycles after acceptance.
module main_mem_resp #(
    parameter int LATENCY = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req,
    input  logic         read_write,
    input  logic [9:0]   Address,
    input  logic [31:0]  write_data,
    output logic [127:0] read_data,
    output logic         ready,
    output logic         busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] COUNT_LOAD = 4'(LATENCY - 1);
    localparam bit         SINGLE_CYCLE = (LATENCY == 1);

    logic [1:0]  state;
    logic [3:0]  count;
    logic        lat_rw;
    logic [7:0]  lat_word;
    logic [31:0] lat_wdata;

    logic        op_rw;
    logic [7:0]  op_word;
    logic [31:0] op_wdata;
    logic        enter_done;
    logic        addr_unused;

    logic [31:0] mem [256] = '{default: 32'h0};

    assign addr_unused = ^Address[1:0];

    // With LATENCY = 1 the access happens on the accepting edge, so the live inputs are used.
    always_comb begin
        op_rw      = lat_rw;
        op_word    = lat_word;
        op_wdata   = lat_wdata;
        enter_done = 1'b0;
        if (state == IDLE) begin
            op_rw    = read_write;
            op_word  = Address[9:2];
            op_wdata = write_data;
        end
        if (!reset) begin
            enter_done = (state == IDLE && req && SINGLE_CYCLE) ||
                         (state == WAIT && count == 4'd1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            count     <= 4'd0;
            lat_rw    <= 1'b0;
            lat_word  <= 8'd0;
            lat_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_rw    <= read_write;
                        lat_word  <= Address[9:2];
                        lat_wdata <= write_data;
                        count     <= COUNT_LOAD;
                        state     <= SINGLE_CYCLE ? DONE : WAIT;
                    end
                end
                WAIT: begin
                    count <= count - 4'd1;
                    if (count == 4'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // read_data only changes when a read completes; writes leave it alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data <= 128'h0;
        end else if (enter_done && !op_rw) begin
            read_data <= {mem[{op_word[7:2], 2'd3}], mem[{op_word[7:2], 2'd2}],
                          mem[{op_word[7:2], 2'd1}], mem[{op_word[7:2], 2'd0}]};
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (enter_done && op_rw) begin
            mem[op_word] <= op_wdata;
        end
    end

    assign ready = (state == DONE);
    assign busy  = (state != IDLE);

endmodule

// File: tb/tb_main_mem_resp.sv
// Directed self-checking bench for main_mem_resp: a LATENCY=4 instance for the main
// scenarios and a LATENCY=1 instance for continuous back-to-back requests.
module tb_main_mem_resp;

    logic         clk;
    logic         reset;

    logic         req4, rw4, ready4, busy4;
    logic [9:0]   addr4;
    logic [31:0]  wd4;
    logic [127:0] rdata4;

    logic         req1, rw1, ready1, busy1;
    logic [9:0]   addr1;
    logic [31:0]  wd1;
    logic [127:0] rdata1;

    int vectors = 0;
    int miscompares = 0;

    main_mem_resp #(.LATENCY(4)) u4 (
        .clk(clk), .reset(reset), .req(req4), .read_write(rw4), .Address(addr4),
        .write_data(wd4), .read_data(rdata4), .ready(ready4), .busy(busy4)
    );

    main_mem_resp #(.LATENCY(1)) u1 (
        .clk(clk), .reset(reset), .req(req1), .read_write(rw1), .Address(addr1),
        .write_data(wd1), .read_data(rdata1), .ready(ready1), .busy(busy1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Called at a negedge with u4 idle; returns at the negedge after the ready cycle.
    task automatic applyStimulus(input string tag, input logic rw, input logic [9:0] addr,
                                 input logic [31:0] wd);
        int lat;
        req4  = 1'b1;
        rw4   = rw;
        addr4 = addr;
        wd4   = wd;
        @(posedge clk);
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req4 = 1'b0;
            lat++;
            if (ready4) break;
        end
        checkOutput({tag, "_latency"}, 128'(lat), 128'(4));
        @(negedge clk);
        checkOutput({tag, "_idle_after"}, {126'h0, ready4, busy4}, 128'h0);
    endtask

    initial begin
        int ready_count;
        logic exp_phase;

        reset = 1'b1;
        req4 = 1'b0; rw4 = 1'b0; addr4 = 10'h0; wd4 = 32'h0;
        req1 = 1'b0; rw1 = 1'b0; addr1 = 10'h0; wd1 = 32'h0;
        #2;
        checkOutput("reset_rdata", rdata4, 128'h0);
        checkOutput("reset_ready_busy", {126'h0, ready4, busy4}, 128'h0);
        @(negedge clk);
        reset = 1'b0;

        // Write DEADBEEF to 0x048, cycle-by-cycle; inputs scrambled after acceptance.
        @(negedge clk);
        req4 = 1'b1; rw4 = 1'b1; addr4 = 10'h048; wd4 = 32'hDEADBEEF;
        @(posedge clk);
        @(negedge clk);
        req4 = 1'b0; rw4 = 1'b0; addr4 = 10'h3FF; wd4 = 32'h0;
        checkOutput("wr_e0_ready_busy", {126'h0, ready4, busy4}, 128'h1);
        @(negedge clk);
        checkOutput("wr_e1_ready_busy", {126'h0, ready4, busy4}, 128'h1);
        @(negedge clk);
        checkOutput("wr_e2_ready_busy", {126'h0, ready4, busy4}, 128'h1);
        @(negedge clk);
        checkOutput("wr_e3_ready_busy", {126'h0, ready4, busy4}, 128'h3);
        @(negedge clk);
        checkOutput("wr_e4_ready_busy", {126'h0, ready4, busy4}, 128'h0);
        checkOutput("wr_rdata_unchanged", rdata4, 128'h0);

        applyStimulus("rd_040", 1'b0, 10'h040, 32'h0);
        checkOutput("rd_040_data", rdata4, {32'h0, 32'hDEADBEEF, 64'h0});

        applyStimulus("wr_3f0", 1'b1, 10'h3F0, 32'h1);
        applyStimulus("wr_3f4", 1'b1, 10'h3F4, 32'h2);
        applyStimulus("wr_3f8", 1'b1, 10'h3F8, 32'h3);
        applyStimulus("wr_3fc", 1'b1, 10'h3FC, 32'h4);
        checkOutput("wr_3fc_rdata_held", rdata4, {32'h0, 32'hDEADBEEF, 64'h0});
        applyStimulus("rd_3f4", 1'b0, 10'h3F4, 32'h0);
        checkOutput("rd_3f4_data", rdata4, 128'h00000004_00000003_00000002_00000001);

        // Read of block 0 with a write request held high through busy and DONE.
        req4 = 1'b1; rw4 = 1'b0; addr4 = 10'h000; wd4 = 32'h0;
        @(posedge clk);
        @(negedge clk);
        rw4 = 1'b1; wd4 = 32'h1234;
        ready_count = 0;
        for (int i = 0; i < 20; i++) begin
            if (ready4) break;
            @(negedge clk);
            ready_count++;
        end
        checkOutput("busy_req_latency", 128'(ready_count), 128'(3));
        @(negedge clk);
        checkOutput("done_req_ignored", {126'h0, ready4, busy4}, 128'h0);
        req4 = 1'b0;
        checkOutput("busy_req_rdata", rdata4, 128'h0);
        applyStimulus("rd_000", 1'b0, 10'h000, 32'h0);
        checkOutput("rd_000_data", rdata4, 128'h0);

        applyStimulus("rd_3f0", 1'b0, 10'h3F0, 32'h0);
        checkOutput("rd_3f0_data", rdata4, 128'h00000004_00000003_00000002_00000001);

        // Write to 0x010 aborted by a reset arriving just after edge 2.
        req4 = 1'b1; rw4 = 1'b1; addr4 = 10'h010; wd4 = 32'hA5A5A5A5;
        @(posedge clk);
        @(negedge clk);
        req4 = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        checkOutput("abort_ready_busy", {126'h0, ready4, busy4}, 128'h0);
        checkOutput("abort_rdata", rdata4, 128'h0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus("rd_010", 1'b0, 10'h010, 32'h0);
        checkOutput("rd_010_data", rdata4, 128'h0);

        // LATENCY=1: single write, then reads with req held high continuously.
        @(negedge clk);
        req1 = 1'b1; rw1 = 1'b1; addr1 = 10'h00C; wd1 = 32'hCAFEF00D;
        @(posedge clk);
        @(negedge clk);
        checkOutput("l1_wr_ready_busy", {126'h0, ready1, busy1}, 128'h3);
        rw1 = 1'b0; addr1 = 10'h000;
        @(negedge clk);
        checkOutput("l1_done_req_ignored", {126'h0, ready1, busy1}, 128'h0);
        ready_count = 0;
        exp_phase = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput($sformatf("l1_cycle%0d", i), {126'h0, ready1, busy1},
                        {126'h0, exp_phase, exp_phase});
            if (ready1) ready_count++;
            exp_phase = ~exp_phase;
        end
        req1 = 1'b0;
        checkOutput("l1_completions", 128'(ready_count), 128'(4));
        checkOutput("l1_rdata", rdata1, {32'hCAFEF00D, 96'h0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
